track_gen: RTL and testbench

- Stimulus source for the label-tracking checker. Drives its two ping-pong client ports with mark (create) and clear (remove) events.
- Keeps a pool of outstanding labels. Clears them oldest-first once the pool reaches a hold threshold.
- Can inject deliberate protocol violations (duplicate mark, clear of an unmarked label) to exercise the checker's error path.
- Sits beside the checker in FIFO/tracking unit benches.

---
 rtl/track_gen.sv | 177 +++++++++++++++++
 tb/tb_track_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/track_gen.sv
// track_gen: stimulus source for the label-tracking checker.
// Issues mark events on port 1 and clear events on port 2, keeping a FIFO
// pool of outstanding labels that is cleared oldest-first once occupancy
// reaches the hold threshold. Can inject a duplicate mark or a ghost clear.
//
// Handshake: there is no ready/valid pair. A strobe (we1/we2) is a one-cycle
// valid; track_fifo_full acts as the inverse of ready and blocks every issue
// decision in the cycle it is high. A blocked event is simply re-evaluated
// the next cycle, so nothing is lost.
module track_gen #(
  parameter int LABELWIDTH = 20,
  parameter int DEPTHWIDTH = 4,
  parameter int STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  drain,
  input  logic [DEPTHWIDTH:0]   hold_count,
  input  logic                  inject_dup,
  input  logic                  inject_ghost,
  input  logic                  track_fifo_full,
  output logic                  track_fifo_we1,
  output logic [LABELWIDTH-1:0] track_label1,
  output logic                  track_mark1,
  output logic                  track_fifo_we2,
  output logic [LABELWIDTH-1:0] track_label2,
  output logic                  track_mark2,
  output logic [DEPTHWIDTH:0]   outstanding,
  output logic [31:0]           issued_count,
  output logic                  done
);

  localparam int DEPTH = 1 << DEPTHWIDTH;
  localparam logic [DEPTHWIDTH:0]   CAPACITY  = (DEPTHWIDTH+1)'(DEPTH);
  localparam logic [DEPTHWIDTH:0]   ONE_CNT   = (DEPTHWIDTH+1)'(1);
  localparam logic [LABELWIDTH-1:0] STRIDE_L  = LABELWIDTH'(STRIDE);
  localparam logic [LABELWIDTH-1:0] LABEL_MSB = {1'b1, {(LABELWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [LABELWIDTH-1:0]   pool_q [DEPTH];
  logic [DEPTHWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTHWIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTHWIDTH:0]     count_q, count_d;
  logic [LABELWIDTH-1:0]   next_label_q, next_label_d;
  logic                    dup_q, dup_d;
  logic                    ghost_q, ghost_d;

  logic                    we1_q, we1_d;
  logic [LABELWIDTH-1:0]   label1_q, label1_d;
  logic                    we2_q, we2_d;
  logic [LABELWIDTH-1:0]   label2_q, label2_d;
  logic [31:0]             issued_q, issued_d;
  logic                    done_q, done_d;

  logic [DEPTHWIDTH:0]     hold_eff;
  logic [LABELWIDTH-1:0]   label_inc;
  logic [LABELWIDTH-1:0]   pool_head;
  logic                    mark_slot, dup_fire, push;
  logic                    clear_gate, ghost_fire, pop;

  // Issue decisions for both ports plus pool/label bookkeeping
  always_comb begin
    hold_eff  = (hold_count == '0) ? ONE_CNT : hold_count;
    pool_head = pool_q[rd_ptr_q];
    label_inc = next_label_q + STRIDE_L;

    // Mark port: RUN, enabled, room in the pool, not full, not strobed last cycle
    mark_slot = (state_q == ST_RUN) && enable && (count_q < CAPACITY) &&
                !track_fifo_full && !we1_q;
    dup_fire  = mark_slot && dup_q && (count_q != '0);
    push      = mark_slot && !dup_fire;

    // Clear port: a pending ghost wins the slot and ignores occupancy rules
    clear_gate = !track_fifo_full && !we2_q;
    ghost_fire = clear_gate && ghost_q;
    pop        = clear_gate && !ghost_q && (count_q != '0) &&
                 ((count_q >= hold_eff) || (state_q == ST_DRAIN));

    we1_d    = push || dup_fire;
    label1_d = '0;
    if (dup_fire)  label1_d = pool_head;
    else if (push) label1_d = next_label_q;

    we2_d    = pop || ghost_fire;
    label2_d = '0;
    if (ghost_fire) label2_d = next_label_q ^ LABEL_MSB;
    else if (pop)   label2_d = pool_head;

    issued_d = issued_q + 32'(we1_d) + 32'(we2_d);

    next_label_d = next_label_q;
    if (push) next_label_d = (label_inc == '0) ? STRIDE_L : label_inc;

    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // FSM next state and sticky injection flags
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain) state_d = ST_DRAIN;
      ST_DRAIN: if ((count_q == '0) && !dup_q && !ghost_q) state_d = ST_DONE;
      ST_DONE:  if (!drain) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    // A duplicate can only fire in RUN, so it is dropped while draining
    dup_d = dup_q | inject_dup;
    if (dup_fire) dup_d = 1'b0;
    if (state_d == ST_DRAIN) dup_d = 1'b0;

    ghost_d = ghost_q | inject_ghost;
    if (ghost_fire) ghost_d = 1'b0;

    done_d = (state_d == ST_DONE);
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      next_label_q <= LABELWIDTH'(1);
      dup_q        <= 1'b0;
      ghost_q      <= 1'b0;
      we1_q        <= 1'b0;
      label1_q     <= '0;
      we2_q        <= 1'b0;
      label2_q     <= '0;
      issued_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      next_label_q <= next_label_d;
      dup_q        <= dup_d;
      ghost_q      <= ghost_d;
      we1_q        <= we1_d;
      label1_q     <= label1_d;
      we2_q        <= we2_d;
      label2_q     <= label2_d;
      issued_q     <= issued_d;
      done_q       <= done_d;
    end
  end

  // Pool storage; contents are meaningless while count is zero, so no reset
  always_ff @(posedge clk) begin
    if (push && !reset) pool_q[wr_ptr_q] <= next_label_q;
  end

  assign track_fifo_we1 = we1_q;
  assign track_label1   = label1_q;
  assign track_mark1    = we1_q;
  assign track_fifo_we2 = we2_q;
  assign track_label2   = label2_q;
  assign track_mark2    = 1'b0;
  assign outstanding    = count_q;
  assign issued_count   = issued_q;
  assign done           = done_q;

endmodule

// File: tb/tb_track_gen.sv
// Directed testbench for track_gen with a label scoreboard.
module tb_track_gen;

  localparam int LW = 20;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          drain;
  logic [DW:0]   hold_count;
  logic          inject_dup;
  logic          inject_ghost;
  logic          track_fifo_full;
  logic          track_fifo_we1;
  logic [LW-1:0] track_label1;
  logic          track_mark1;
  logic          track_fifo_we2;
  logic [LW-1:0] track_label2;
  logic          track_mark2;
  logic [DW:0]   outstanding;
  logic [31:0]   issued_count;
  logic          done;

  track_gen #(.LABELWIDTH(LW), .DEPTHWIDTH(DW), .STRIDE(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .drain           (drain),
    .hold_count      (hold_count),
    .inject_dup      (inject_dup),
    .inject_ghost    (inject_ghost),
    .track_fifo_full (track_fifo_full),
    .track_fifo_we1  (track_fifo_we1),
    .track_label1    (track_label1),
    .track_mark1     (track_mark1),
    .track_fifo_we2  (track_fifo_we2),
    .track_label2    (track_label2),
    .track_mark2     (track_mark2),
    .outstanding     (outstanding),
    .issued_count    (issued_count),
    .done            (done)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state: labels expected to be outstanding, oldest first
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] exp_next;
  logic [LW-1:0] ghost_exp;
  int            n_checks = 0;
  int            n_errors = 0;
  int            dup_req = 0, dup_seen = 0;
  int            ghost_req = 0, ghost_seen = 0;
  int            ev_count = 0;
  int            clear_total = 0;
  logic          prev_we1 = 1'b0, prev_we2 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: runs once per cycle on the falling edge
  task automatic monitor();
    logic [LW-1:0] head;
    if (reset) begin
      exp_q.delete();
      exp_next   = 1;
      ev_count   = 0;
      prev_we1   = 1'b0;
      prev_we2   = 1'b0;
      dup_seen   = dup_req;
      ghost_seen = ghost_req;
      return;
    end
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    if (track_fifo_we2) begin
      check("we2_spacing", 32'(prev_we2), 0);
      check("mark2", 32'(track_mark2), 0);
      if (ghost_req > ghost_seen) begin
        check("ghost_label", 32'(track_label2), 32'(ghost_exp));
        ghost_seen++;
      end else if (exp_q.size() == 0) begin
        check("clear_underflow", 1, 0);
      end else begin
        check("clear_label", 32'(track_label2), 32'(exp_q.pop_front()));
        clear_total++;
      end
    end
    if (track_fifo_we1) begin
      check("we1_spacing", 32'(prev_we1), 0);
      check("mark1", 32'(track_mark1), 1);
      if (dup_req > dup_seen) begin
        check("dup_label", 32'(track_label1), 32'(head));
        dup_seen++;
      end else begin
        check("mark_label", 32'(track_label1), 32'(exp_next));
        exp_q.push_back(exp_next);
        exp_next = exp_next + 1'b1;
      end
    end
    ev_count += int'(track_fifo_we1) + int'(track_fifo_we2);
    prev_we1 = track_fifo_we1;
    prev_we2 = track_fifo_we2;
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_out(input int val, input int budget, input string tag);
    int n = 0;
    while (int'(outstanding) != val && n < budget) begin step(); n++; end
    check(tag, 32'(outstanding), 32'(val));
  endtask

  task automatic wait_we1(input int budget, input string tag);
    int n = 0;
    while (!track_fifo_we1 && n < budget) begin step(); n++; end
    check(tag, 32'(track_fifo_we1), 1);
  endtask

  task automatic wait_we2(input int budget, input string tag);
    int n = 0;
    while (!track_fifo_we2 && n < budget) begin step(); n++; end
    check(tag, 32'(track_fifo_we2), 1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin step(); n++; end
    check(tag, 32'(done), 1);
  endtask

  initial begin
    int o0;
    int clr0;
    reset = 1'b1; enable = 1'b0; drain = 1'b0; hold_count = 5'd4;
    inject_dup = 1'b0; inject_ghost = 1'b0; track_fifo_full = 1'b0;
    ghost_exp = '0;
    exp_next  = 1;
    @(negedge clk);
    step();
    step();

    // Reset state
    check("rst_we1", 32'(track_fifo_we1), 0);
    check("rst_we2", 32'(track_fifo_we2), 0);
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_issued", issued_count, 0);
    check("rst_done", 32'(done), 0);
    check("rst_label1", 32'(track_label1), 0);

    // Basic flow, hold threshold 4: first clear one cycle after reaching 4
    reset = 1'b0; enable = 1'b1;
    wait_out(4, 20, "reach4");
    step();
    check("first_clear_we2", 32'(track_fifo_we2), 1);
    check("first_clear_label", 32'(track_label2), 1);
    repeat (20) step();

    // Stall with the request FIFO full for 10 cycles
    track_fifo_full = 1'b1;
    o0 = int'(outstanding);
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_we1", 32'(track_fifo_we1), 0);
      check("stall_we2", 32'(track_fifo_we2), 0);
      check("stall_outstanding", 32'(outstanding), 32'(o0));
      if (i == 9) track_fifo_full = 1'b0;
    end
    repeat (20) step();

    // hold_count of 0 behaves as 1: each mark is cleared right after
    do_reset();
    hold_count = 5'd0; enable = 1'b1;
    wait_we1(5, "hold0_mark");
    check("hold0_mark_label", 32'(track_label1), 1);
    step();
    check("hold0_clear_we2", 32'(track_fifo_we2), 1);
    check("hold0_clear_label", 32'(track_label2), 1);
    check("hold0_outstanding", 32'(outstanding), 0);
    repeat (10) step();

    // Fill to capacity (threshold above capacity so nothing is cleared), then drain
    do_reset();
    hold_count = 5'd31; enable = 1'b1;
    wait_out(16, 60, "fill16");
    for (int i = 0; i < 4; i++) begin
      step();
      check("full_pool_we1", 32'(track_fifo_we1), 0);
      check("full_pool_outstanding", 32'(outstanding), 16);
    end
    clr0 = clear_total;
    drain = 1'b1;
    wait_done(60, "drain_done");
    check("drain_outstanding", 32'(outstanding), 0);
    check("drain_clears", 32'(clear_total - clr0), 16);
    check("drain_sb_empty", 32'(exp_q.size()), 0);
    drain = 1'b0;
    step();
    check("done_drop", 32'(done), 0);
    wait_we1(10, "resume_mark");
    check("resume_label", 32'(track_label1), 17);

    // Duplicate mark after three labels are outstanding
    do_reset();
    hold_count = 5'd31; enable = 1'b1;
    wait_out(3, 20, "reach3");
    inject_dup = 1'b1; dup_req++;
    step();
    inject_dup = 1'b0;
    wait_we1(10, "dup_we1");
    check("dup_label1", 32'(track_label1), 1);
    check("dup_outstanding", 32'(outstanding), 3);
    step();
    wait_we1(10, "after_dup_we1");
    check("after_dup_label1", 32'(track_label1), 4);
    check("after_dup_outstanding", 32'(outstanding), 4);

    // Ghost clear with next_label = 5
    enable = 1'b0;
    ghost_exp = 20'h80005;
    inject_ghost = 1'b1; ghost_req++;
    step();
    inject_ghost = 1'b0;
    wait_we2(10, "ghost_we2");
    check("ghost_label2", 32'(track_label2), 32'h80005);
    check("ghost_mark2", 32'(track_mark2), 0);
    check("ghost_no_pop", 32'(outstanding), 4);

    // Reset in the middle of a drain with seven outstanding
    enable = 1'b1;
    wait_out(7, 20, "reach7");
    enable = 1'b0; drain = 1'b1;
    step();
    check("pre_reset_outstanding", 32'(outstanding), 7);
    check("pre_reset_done", 32'(done), 0);
    reset = 1'b1;
    step();
    check("midrst_we1", 32'(track_fifo_we1), 0);
    check("midrst_we2", 32'(track_fifo_we2), 0);
    check("midrst_outstanding", 32'(outstanding), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_issued", issued_count, 0);
    reset = 1'b0; drain = 1'b0; enable = 1'b1;
    wait_we1(5, "postrst_mark");
    check("postrst_label", 32'(track_label1), 1);
    repeat (6) step();
    check("issued_total", issued_count, 32'(ev_count));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
